// File: rtl/pc_seq_pkg.sv
// Shared definitions for the next-PC sequencer: FSM state type, default sizes,
// and the absolute-jump lookup table used when JUMP_LUT_EN is defined.
// No ports; imported by pc_sequencer and its testbench.
package pc_seq_pkg;

  localparam int D_DEF         = 12;
  localparam int RAS_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  // Absolute jump/call targets selected by imm[3:0] in the LUT build.
  localparam logic [D_DEF-1:0] JUMP_LUT [16] = '{
    12'h100, 12'h111, 12'h122, 12'h133, 12'h144, 12'h155, 12'h166, 12'h177,
    12'h188, 12'h199, 12'h1AA, 12'h1BB, 12'h1CC, 12'h1DD, 12'h1EE, 12'h1FF
  };

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder/PC <-> sequencer bundle. Decoded control-flow fields and current PC in,
// reljump/absjump/target to the PC plus status flags out.
// master = decoder/PC side, slave = sequencer side.
interface pc_sequencer_if #(parameter int D = 12);

  logic         start;
  logic         stall;
  logic         halt_req;
  logic         br_rel;
  logic         br_abs;
  logic         call;
  logic         ret;
  logic         cond;
  logic [D-1:0] imm;
  logic [D-1:0] prog_ctr;
  logic         reljump;
  logic         absjump;
  logic [D-1:0] target;
  logic         busy;
  logic         done;
  logic         ras_ovf;
  logic         ras_udf;

  modport master (
    output start, stall, halt_req, br_rel, br_abs, call, ret, cond, imm, prog_ctr,
    input  reljump, absjump, target, busy, done, ras_ovf, ras_udf
  );

  modport slave (
    input  start, stall, halt_req, br_rel, br_abs, call, ret, cond, imm, prog_ctr,
    output reljump, absjump, target, busy, done, ras_ovf, ras_udf
  );

endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Return-address stack: DEPTH entries of D bits, count register 0..DEPTH.
// Latency: push/pop take effect at the next edge; top_o is combinational from state.
// Ports: push_i/push_dat_i, pop_i, top_o, full_o, empty_o. Push while full and
// pop while empty are ignored here; the parent decides what that means.
module ras_stack #(
  parameter int D     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [D-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [D-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [D-1:0]  mem_q [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  // Top entry sits just below the count; value is meaningless when empty.
  assign top_o   = mem_q[AW'(cnt_q - CW'(1))];

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !full_o)      cnt_d = cnt_q + CW'(1);
    else if (pop_i && !empty_o) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Storage is deliberately not reset; only the count defines validity.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[AW'(cnt_q)] <= push_dat_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: start/halt sequencing, stall-as-hold, branches, call/return via RAS.
// Latency: outputs combinational from registered state + inputs; PC updates next edge.
// No backpressure; stall holds PC. Ports: clk, reset (async active-low), bus (slave).
// Optional JUMP_LUT_EN: br_abs/call targets come from pc_seq_pkg::JUMP_LUT[imm[3:0]].
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int D         = D_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  state_e       state_q, state_d;
  logic         ovf_q, ovf_d;
  logic         udf_q, udf_d;
  logic         push, pop;
  logic         ras_full, ras_empty;
  logic [D-1:0] ras_top;
  logic [D-1:0] ret_addr;
  logic [D-1:0] abs_tgt;
  logic         rel_o, abs_o;
  logic [D-1:0] tgt_o;

  assign ret_addr = bus.prog_ctr + D'(1);

`ifdef JUMP_LUT_EN
  assign abs_tgt = D'(JUMP_LUT[bus.imm[3:0]]);
`else
  assign abs_tgt = bus.imm;
`endif

  ras_stack #(.D(D), .DEPTH(RAS_DEPTH)) u_ras (
    .clk        (clk),
    .rst_n      (reset),
    .push_i     (push),
    .push_dat_i (ret_addr),
    .pop_i      (pop),
    .top_o      (ras_top),
    .full_o     (ras_full),
    .empty_o    (ras_empty)
  );

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    push    = 1'b0;
    pop     = 1'b0;
    // Default is "hold": reload the current PC.
    rel_o   = 1'b0;
    abs_o   = 1'b1;
    tgt_o   = bus.prog_ctr;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        if (bus.halt_req) begin
          state_d = HALT;
        end else if (bus.stall) begin
          // hold; nothing else considered
        end else if (bus.ret) begin
          if (ras_empty) begin
            udf_d   = 1'b1;
            state_d = HALT;
          end else begin
            tgt_o = ras_top;
            pop   = 1'b1;
          end
        end else if (bus.call) begin
          tgt_o = abs_tgt;
          push  = 1'b1;
          // Jump is taken even when the return address cannot be saved.
          if (ras_full) ovf_d = 1'b1;
        end else if (bus.br_abs) begin
          tgt_o = abs_tgt;
        end else if (bus.br_rel && bus.cond) begin
          abs_o = 1'b0;
          rel_o = 1'b1;
          tgt_o = bus.imm;
        end else begin
          abs_o = 1'b0;
          tgt_o = '0;
        end
      end
      HALT: begin
        // only reset leaves HALT
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign bus.reljump = rel_o;
  assign bus.absjump = abs_o;
  assign bus.target  = tgt_o;
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == HALT);
  assign bus.ras_ovf = ovf_q;
  assign bus.ras_udf = udf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer with a scoreboard queue and a PC plant model.
// Each vector: control bits, imm, expected PC (optionally forced), expected outputs.
// Hand-written steps cover the asynchronous reset in the middle of RUN.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int D = 12;

  // ctl bit positions: {start, stall, halt_req, br_rel, br_abs, call, ret, cond}
  localparam logic [7:0] C_START = 8'h80, C_STALL = 8'h40, C_HALT = 8'h20, C_BRR = 8'h10;
  localparam logic [7:0] C_BRA = 8'h08, C_CALL = 8'h04, C_RET = 8'h02, C_COND = 8'h01;
  // output bit positions: {reljump, absjump, busy, done, ras_ovf, ras_udf}
  localparam logic [5:0] O_REL = 6'h20, O_ABS = 6'h10, O_BUSY = 6'h08;
  localparam logic [5:0] O_DONE = 6'h04, O_OVF = 6'h02, O_UDF = 6'h01;
  localparam logic [5:0] AB = O_ABS | O_BUSY;

  typedef struct {
    logic [7:0]   ctl;
    logic [D-1:0] imm;
    logic         ld;    // force the PC to pcv instead of checking it
    logic [D-1:0] pcv;
    logic [5:0]   eout;
    logic [D-1:0] etgt;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if #(.D(D)) bus ();
  pc_sequencer #(.D(D), .RAS_DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  vec_t         tbl[$];
  vec_t         exp_q[$];
  int           n_vec = 0;
  int           n_bad = 0;
  logic [D-1:0] pc = '0;
  logic [D-1:0] a1, a2, a3, a4, a5, a9, a50;

  function automatic logic [D-1:0] at(input logic [D-1:0] im);
`ifdef JUMP_LUT_EN
    return D'(JUMP_LUT[im[3:0]]);
`else
    return im;
`endif
  endfunction

  function automatic vec_t mk(input logic [7:0] c, input logic [D-1:0] im, input logic l,
                              input logic [D-1:0] p, input logic [5:0] o, input logic [D-1:0] t);
    vec_t v;
    v.ctl = c; v.imm = im; v.ld = l; v.pcv = p; v.eout = o; v.etgt = t;
    return v;
  endfunction

  task automatic check_now();
    vec_t       e;
    logic [5:0] got;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: no expectation queued");
      return;
    end
    e   = exp_q.pop_front();
    got = {bus.reljump, bus.absjump, bus.busy, bus.done, bus.ras_ovf, bus.ras_udf};
    n_vec++;
    if (got !== e.eout) begin
      n_bad++;
      $display("FAIL flags vec %0d: got %b want %b (rel,abs,busy,done,ovf,udf)", n_vec, got, e.eout);
    end
    if (bus.target !== e.etgt) begin
      n_bad++;
      $display("FAIL target vec %0d: got %h want %h", n_vec, bus.target, e.etgt);
    end
    if (!e.ld && bus.prog_ctr !== e.pcv) begin
      n_bad++;
      $display("FAIL pc vec %0d: got %h want %h", n_vec, bus.prog_ctr, e.pcv);
    end
    if (bus.reljump && bus.absjump) begin
      n_bad++;
      $display("FAIL exclusive vec %0d: reljump and absjump both 1", n_vec);
    end
  endtask

  // Called at a negedge; returns at the following negedge with the PC advanced.
  task automatic apply(input vec_t v);
    logic [D-1:0] nxt;
    {bus.start, bus.stall, bus.halt_req, bus.br_rel, bus.br_abs, bus.call, bus.ret, bus.cond} = v.ctl;
    bus.imm = v.imm;
    if (v.ld) pc = v.pcv;
    bus.prog_ctr = pc;
    exp_q.push_back(v);
    #2;
    check_now();
    // PC plant: load, add, or increment, all mod 2^D.
    nxt = bus.absjump ? bus.target : bus.reljump ? pc + bus.target : pc + D'(1);
    @(posedge clk);
    pc = nxt;
    @(negedge clk);
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask

  task automatic do_reset();
    {bus.start, bus.stall, bus.halt_req, bus.br_rel, bus.br_abs, bus.call, bus.ret, bus.cond} = 8'h00;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a1 = at(12'd200); a2 = at(12'd300); a3 = at(12'd400); a4 = at(12'd500); a5 = at(12'd600);
    a9 = at(12'd9); a50 = at(12'd50);
    bus.imm = '0; bus.prog_ctr = '0;
    {bus.start, bus.stall, bus.halt_req, bus.br_rel, bus.br_abs, bus.call, bus.ret, bus.cond} = 8'h00;
    reset = 1'b0;
    @(negedge clk);
    // Reset held: IDLE hold outputs.
    tbl.push_back(mk(8'h00, 12'd0, 1'b1, 12'd0, O_ABS, 12'd0));
    run_tbl();
    reset = 1'b1;

    // Start, increment, relative branches, call/ret, wrap, absolute jump.
    tbl.push_back(mk(8'h00,          12'd0,   1'b1, 12'd0,   O_ABS,        12'd0));
    tbl.push_back(mk(C_START,        12'd0,   1'b0, 12'd0,   O_ABS,        12'd0));
    tbl.push_back(mk(8'h00,          12'd0,   1'b0, 12'd0,   O_BUSY,       12'd0));
    tbl.push_back(mk(8'h00,          12'd0,   1'b0, 12'd1,   O_BUSY,       12'd0));
    tbl.push_back(mk(8'h00,          12'd0,   1'b0, 12'd2,   O_BUSY,       12'd0));
    tbl.push_back(mk(8'h00,          12'd0,   1'b0, 12'd3,   O_BUSY,       12'd0));
    tbl.push_back(mk(C_BRR | C_COND, 12'hFFD, 1'b1, 12'd10,  O_REL|O_BUSY, 12'hFFD));
    tbl.push_back(mk(8'h00,          12'd0,   1'b0, 12'd7,   O_BUSY,       12'd0));
    tbl.push_back(mk(C_BRR,          12'hFFD, 1'b1, 12'd10,  O_BUSY,       12'd0));
    tbl.push_back(mk(8'h00,          12'd0,   1'b0, 12'd11,  O_BUSY,       12'd0));
    tbl.push_back(mk(C_CALL,         12'd40,  1'b1, 12'd5,   AB,           at(12'd40)));
    tbl.push_back(mk(8'h00,          12'd0,   1'b1, 12'd42,  O_BUSY,       12'd0));
    tbl.push_back(mk(C_RET,          12'd0,   1'b0, 12'd43,  AB,           12'd6));
    tbl.push_back(mk(8'h00,          12'd0,   1'b0, 12'd6,   O_BUSY,       12'd0));
    tbl.push_back(mk(C_BRR | C_COND, 12'd5,   1'b1, 12'hFFE, O_REL|O_BUSY, 12'd5));
    tbl.push_back(mk(8'h00,          12'd0,   1'b0, 12'd3,   O_BUSY,       12'd0));
    tbl.push_back(mk(C_BRA,          12'd3,   1'b0, 12'd4,   AB,           at(12'd3)));
    tbl.push_back(mk(8'h00,          12'd0,   1'b0, at(12'd3), O_BUSY,     12'd0));
    run_tbl();

    // Nested calls past RAS depth, then unwind to underflow and HALT.
    do_reset();
    tbl.push_back(mk(C_START, 12'd0,   1'b1, 12'd0,   O_ABS,       12'd0));
    tbl.push_back(mk(C_CALL,  12'd200, 1'b1, 12'd100, AB,          a1));
    tbl.push_back(mk(C_CALL,  12'd300, 1'b0, a1,      AB,          a2));
    tbl.push_back(mk(C_CALL,  12'd400, 1'b0, a2,      AB,          a3));
    tbl.push_back(mk(C_CALL,  12'd500, 1'b0, a3,      AB,          a4));
    tbl.push_back(mk(C_CALL,  12'd600, 1'b0, a4,      AB,          a5));
    tbl.push_back(mk(C_RET,   12'd0,   1'b0, a5,      AB|O_OVF,    a3 + 12'd1));
    tbl.push_back(mk(C_RET,   12'd0,   1'b0, a3 + 12'd1, AB|O_OVF, a2 + 12'd1));
    tbl.push_back(mk(C_RET,   12'd0,   1'b0, a2 + 12'd1, AB|O_OVF, a1 + 12'd1));
    tbl.push_back(mk(C_RET,   12'd0,   1'b0, a1 + 12'd1, AB|O_OVF, 12'd101));
    tbl.push_back(mk(C_RET,   12'd0,   1'b0, 12'd101, AB|O_OVF,    12'd101));
    tbl.push_back(mk(C_START, 12'd0,   1'b0, 12'd101, O_ABS|O_DONE|O_OVF|O_UDF, 12'd101));
    tbl.push_back(mk(C_BRA,   12'd5,   1'b0, 12'd101, O_ABS|O_DONE|O_OVF|O_UDF, 12'd101));
    run_tbl();

    // Stall masks call (no push), then a single call/ret pair; second ret underflows.
    do_reset();
    tbl.push_back(mk(C_START,          12'd0,  1'b1, 12'd0,  O_ABS,              12'd0));
    tbl.push_back(mk(C_STALL | C_CALL, 12'd50, 1'b1, 12'd20, AB,                 12'd20));
    tbl.push_back(mk(C_STALL | C_CALL, 12'd50, 1'b0, 12'd20, AB,                 12'd20));
    tbl.push_back(mk(C_STALL | C_CALL, 12'd50, 1'b0, 12'd20, AB,                 12'd20));
    tbl.push_back(mk(C_CALL,           12'd50, 1'b0, 12'd20, AB,                 a50));
    tbl.push_back(mk(C_RET,            12'd0,  1'b0, a50,    AB,                 12'd21));
    tbl.push_back(mk(C_RET,            12'd0,  1'b0, 12'd21, AB,                 12'd21));
    tbl.push_back(mk(8'h00,            12'd0,  1'b0, 12'd21, O_ABS|O_DONE|O_UDF, 12'd21));
    run_tbl();

    // halt_req beats br_abs; HALT ignores start and jumps.
    do_reset();
    tbl.push_back(mk(C_START,         12'd0,  1'b1, 12'd0,  O_ABS,        12'd0));
    tbl.push_back(mk(C_HALT | C_BRA,  12'd77, 1'b1, 12'd30, AB,           12'd30));
    tbl.push_back(mk(C_START,         12'd0,  1'b0, 12'd30, O_ABS|O_DONE, 12'd30));
    tbl.push_back(mk(C_BRA,           12'd77, 1'b0, 12'd30, O_ABS|O_DONE, 12'd30));
    run_tbl();

    // Overflow while running, then async reset mid-cycle at PC=33.
    do_reset();
    tbl.push_back(mk(C_START, 12'd0, 1'b1, 12'd0,  O_ABS,         12'd0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(C_CALL, 12'd9, 1'b1, 12'd0, AB, a9));
    tbl.push_back(mk(8'h00,   12'd0, 1'b1, 12'd33, O_BUSY|O_OVF,  12'd0));
    run_tbl();
    {bus.start, bus.stall, bus.halt_req, bus.br_rel, bus.br_abs, bus.call, bus.ret, bus.cond} = C_BRA;
    bus.imm = 12'd9;
    pc = 12'd33;
    bus.prog_ctr = pc;
    exp_q.push_back(mk(C_BRA, 12'd9, 1'b1, 12'd33, AB|O_OVF, a9));
    #2;
    check_now();
    reset = 1'b0;
    exp_q.push_back(mk(C_BRA, 12'd9, 1'b1, 12'd33, O_ABS, 12'd33));
    #1;
    check_now();
    @(negedge clk);
    reset = 1'b1;
    tbl.push_back(mk(8'h00, 12'd0, 1'b0, 12'd33, O_ABS, 12'd33));
    run_tbl();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
